// File: rtl/phys_regfile_param.sv
// rtl/phys_regfile_param.sv - multi-ported physical register file with per-register ready bits
// Highest-index write port wins on collisions; alloc clears ready and overrides a same-cycle write.
module phys_regfile_param #(
  parameter int NREGS   = 128,
  parameter int XLEN    = 64,
  parameter int NWR     = 4,
  parameter int NRD     = 6,
  parameter int NALLOC  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rready,
  input  logic [NALLOC-1:0]     alloc_en,
  input  logic [NALLOC*AW-1:0]  alloc_addr,
  output logic                  wr_conflict,
  output logic [AW:0]           ready_cnt
);

  logic [NREGS-1:0][XLEN-1:0] r_mem;
  logic [NREGS-1:0]           r_ready;
  logic                       r_conflict;
  logic [AW:0]                r_cnt;

  logic [NWR-1:0]             w_we;
  logic [NALLOC-1:0]          w_alloc;
  logic                       w_conflict;
  logic [NREGS-1:0]           w_ready_nxt;
  logic [AW:0]                w_cnt;

  // With ZERO_R0, traffic to register 0 is dropped before it reaches any state or the conflict check.
  always_comb begin
    w_we    = '0;
    w_alloc = '0;
    for (int i = 0; i < NWR; i++)
      w_we[i] = we[i] && !((ZERO_R0 != 0) && (waddr[i*AW +: AW] == '0));
    for (int k = 0; k < NALLOC; k++)
      w_alloc[k] = alloc_en[k] && !((ZERO_R0 != 0) && (alloc_addr[k*AW +: AW] == '0));
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NWR; i++)
      for (int k = i + 1; k < NWR; k++)
        if (w_we[i] && w_we[k] && (waddr[i*AW +: AW] == waddr[k*AW +: AW]))
          w_conflict = 1'b1;
  end

  // Allocs are applied after writes so they take precedence on the same register.
  always_comb begin
    w_ready_nxt = r_ready;
    for (int i = 0; i < NWR; i++)
      if (w_we[i]) w_ready_nxt[waddr[i*AW +: AW]] = 1'b1;
    for (int k = 0; k < NALLOC; k++)
      if (w_alloc[k]) w_ready_nxt[alloc_addr[k*AW +: AW]] = 1'b0;
  end

  always_comb begin
    w_cnt = '0;
    for (int n = 0; n < NREGS; n++)
      w_cnt = w_cnt + (AW+1)'(w_ready_nxt[n]);
  end

  always_comb begin
    rdata  = '0;
    rready = '0;
    for (int j = 0; j < NRD; j++) begin
      rdata[j*XLEN +: XLEN] = r_mem[raddr[j*AW +: AW]];
      rready[j]             = r_ready[raddr[j*AW +: AW]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++)
          if (w_we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW])) begin
            rdata[j*XLEN +: XLEN] = wdata[i*XLEN +: XLEN];
            rready[j]             = 1'b1;
          end
      end
      if ((ZERO_R0 != 0) && (raddr[j*AW +: AW] == '0)) begin
        rdata[j*XLEN +: XLEN] = '0;
        rready[j]             = 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-index write the last assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem      <= '0;
      r_ready    <= '1;
      r_conflict <= 1'b0;
      r_cnt      <= (AW+1)'(NREGS);
    end else begin
      for (int i = 0; i < NWR; i++)
        if (w_we[i]) r_mem[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
      r_ready    <= w_ready_nxt;
      r_conflict <= w_conflict;
      r_cnt      <= w_cnt;
    end
  end

  assign wr_conflict = r_conflict;
  assign ready_cnt   = r_cnt;

endmodule

// File: tb/tb_phys_regfile_param.sv
// tb/tb_phys_regfile_param.sv - directed scoreboard bench for phys_regfile_param
// Three instances share stimulus: bypass (default), no bypass, and hardwired register 0.
module tb_phys_regfile_param;

  localparam int AW = 7;
  localparam int XW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    we;
  logic [27:0]   waddr;
  logic [255:0]  wdata;
  logic [41:0]   raddr;
  logic [1:0]    alloc_en;
  logic [13:0]   alloc_addr;

  logic [383:0]  rd_b, rd_n, rd_z;
  logic [5:0]    rr_b, rr_n, rr_z;
  logic          wc_b, wc_n, wc_z;
  logic [7:0]    cnt_b, cnt_n, cnt_z;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  phys_regfile_param #(.BYPASS(1), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_b), .rready(rr_b), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .wr_conflict(wc_b), .ready_cnt(cnt_b)
  );

  phys_regfile_param #(.BYPASS(0), .ZERO_R0(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_n), .rready(rr_n), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .wr_conflict(wc_n), .ready_cnt(cnt_n)
  );

  phys_regfile_param #(.BYPASS(1), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_z), .rready(rr_z), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .wr_conflict(wc_z), .ready_cnt(cnt_z)
  );

  function automatic logic [63:0] rd(input logic [383:0] v, input int p);
    return v[p*XW +: XW];
  endfunction

  task automatic push(input string tag, input logic [63:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_w(input int p, input int a, input logic [63:0] d);
    we[p]               = 1'b1;
    waddr[p*AW +: AW]   = 7'(a);
    wdata[p*XW +: XW]   = d;
  endtask

  task automatic set_r(input int p, input int a);
    raddr[p*AW +: AW] = 7'(a);
  endtask

  task automatic set_a(input int p, input int a);
    alloc_en[p]              = 1'b1;
    alloc_addr[p*AW +: AW]   = 7'(a);
  endtask

  task automatic clr_in();
    we       = '0;
    alloc_en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    we = '0; waddr = '0; wdata = '0; raddr = '0; alloc_en = '0; alloc_addr = '0;
    #12;

    // Reset state across every address
    for (int a = 0; a < 128; a += 6) begin
      for (int p = 0; p < 6; p++) begin
        set_r(p, (a + p) % 128);
        push("reset_rdata", 64'h0);
        push("reset_rready", 64'h1);
      end
      #1;
      for (int p = 0; p < 6; p++) begin
        chk(rd(rd_b, p));
        chk(64'(rr_b[p]));
      end
    end
    push("reset_cnt", 64'd128);
    push("reset_conflict", 64'h0);
    chk(64'(cnt_b));
    chk(64'(wc_b));

    @(negedge clk);
    rst_n = 1'b1;

    // Four-way collision on register 5
    set_w(0, 5, 64'hA); set_w(1, 5, 64'hB); set_w(2, 5, 64'hC); set_w(3, 5, 64'hD);
    set_r(0, 5);
    push("collide_bypass_data", 64'hD);
    push("collide_bypass_rready", 64'h1);
    push("collide_nobypass_pre_edge", 64'h0);
    #1;
    chk(rd(rd_b, 0)); chk(64'(rr_b[0])); chk(rd(rd_n, 0));
    tick(); clr_in();
    push("collide_data_nobypass", 64'hD);
    push("collide_data_bypass", 64'hD);
    push("wr_conflict_set", 64'h1);
    push("collide_cnt", 64'd128);
    #1;
    chk(rd(rd_n, 0)); chk(rd(rd_b, 0)); chk(64'(wc_b)); chk(64'(cnt_b));
    tick();
    push("wr_conflict_clear", 64'h0);
    chk(64'(wc_b));

    // Same-cycle bypass on register 9
    set_w(0, 9, 64'h1234); set_r(0, 9);
    push("bypass_data", 64'h1234);
    push("bypass_rready", 64'h1);
    push("nobypass_pre_edge", 64'h0);
    #1;
    chk(rd(rd_b, 0)); chk(64'(rr_b[0])); chk(rd(rd_n, 0));
    tick(); clr_in();
    push("nobypass_post_edge", 64'h1234);
    #1;
    chk(rd(rd_n, 0));

    // Alloc, then alloc plus write on register 17
    set_a(0, 17); set_r(0, 17);
    tick(); clr_in();
    push("alloc_cnt", 64'd127);
    push("alloc_rready", 64'h0);
    #1;
    chk(64'(cnt_b)); chk(64'(rr_b[0]));
    set_a(0, 17); set_w(0, 17, 64'h55);
    push("alloc_write_nobypass_rready", 64'h0);
    push("alloc_write_bypass_rready", 64'h1);
    #1;
    chk(64'(rr_n[0])); chk(64'(rr_b[0]));
    tick(); clr_in();
    push("alloc_wins_rready", 64'h0);
    push("alloc_write_data", 64'h55);
    push("alloc_write_cnt_b", 64'd127);
    push("alloc_write_cnt_n", 64'd127);
    #1;
    chk(64'(rr_b[0])); chk(rd(rd_b, 0)); chk(64'(cnt_b)); chk(64'(cnt_n));

    // Distinct addresses on all write ports, all read ports
    for (int p = 0; p < 4; p++) set_w(p, 20 + p, 64'hC0DE_0000_0000_0000 + 64'(p));
    for (int p = 0; p < 4; p++) set_r(p, 20 + p);
    set_r(4, 5); set_r(5, 9);
    tick(); clr_in();
    for (int p = 0; p < 4; p++) push("multi_write_data", 64'hC0DE_0000_0000_0000 + 64'(p));
    push("read_port4", 64'hD);
    push("read_port5", 64'h1234);
    push("multi_no_conflict", 64'h0);
    #1;
    for (int p = 0; p < 6; p++) chk(rd(rd_n, p));
    chk(64'(wc_n));

    // Register 0 traffic: hardwired on dut_z, ordinary on dut_b
    set_w(0, 0, 64'hFFFF); set_w(1, 0, 64'hFFFF); set_a(0, 0);
    for (int p = 0; p < 6; p++) set_r(p, 0);
    push("r0_bypass_data", 64'h0);
    push("r0_bypass_rready", 64'h1);
    #1;
    chk(rd(rd_z, 0)); chk(64'(rr_z[0]));
    tick(); clr_in();
    push("r0_data", 64'h0);
    push("r0_rready", 64'h1);
    push("r0_cnt_unchanged", 64'd127);
    push("r0_no_conflict", 64'h0);
    push("r0_plain_conflict", 64'h1);
    push("r0_plain_cnt", 64'd126);
    push("r0_plain_data", 64'hFFFF);
    #1;
    chk(rd(rd_z, 0)); chk(64'(rr_z[0])); chk(64'(cnt_z)); chk(64'(wc_z));
    chk(64'(wc_b)); chk(64'(cnt_b)); chk(rd(rd_b, 0));

    // Ten allocs, then asynchronous reset between edges
    set_r(0, 5);
    for (int c = 0; c < 5; c++) begin
      set_a(0, 30 + 2*c); set_a(1, 31 + 2*c);
      tick(); clr_in();
    end
    push("ten_alloc_cnt", 64'd116);
    #1;
    chk(64'(cnt_b));
    #1;
    rst_n = 1'b0;
    push("async_reset_cnt", 64'd128);
    push("async_reset_conflict", 64'h0);
    push("async_reset_data", 64'h0);
    push("async_reset_cnt_n", 64'd128);
    #1;
    chk(64'(cnt_b)); chk(64'(wc_b)); chk(rd(rd_b, 0)); chk(64'(cnt_n));

    // Write presented while reset releases takes effect at the first edge
    @(negedge clk);
    rst_n = 1'b1;
    set_w(0, 40, 64'h77); set_a(0, 41);
    tick(); clr_in();
    set_r(0, 40);
    push("post_reset_write", 64'h77);
    push("post_reset_cnt", 64'd127);
    #1;
    chk(rd(rd_n, 0)); chk(64'(cnt_n));

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
